// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb: round-robin arbiter sharing one host SD block port
// among NDRV 1541 drive emulators.
module c1541_sd_arb #(
  parameter int          NDRV    = 2,
  parameter logic [23:0] TIMEOUT = 24'd16777215
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [32*NDRV-1:0]   drv_lba,
  input  logic [NDRV-1:0]      drv_rd,
  input  logic [NDRV-1:0]      drv_wr,
  output logic [NDRV-1:0]      drv_ack,
  output logic [NDRV-1:0]      drv_buff_wr,
  output logic [NDRV-1:0]      drv_err,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [1:0]           sd_sel,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [31:0]       lba_q, lba_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [NDRV-1:0]   err_q, err_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              old_ack_q;

  logic              found;
  logic [1:0]        gnt;
  logic [31:0]       gnt_lba;
  logic              gnt_wr;

  function automatic logic [1:0] wrap_add(
    input logic [1:0] p,
    input int         o
  );
    int s;
    s = int'(p) + o;
    if (s >= NDRV) s = s - NDRV;
    return 2'(s);
  endfunction

  // Descending offset so the closest requester at/after ptr wins.
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    for (int o = NDRV - 1; o >= 0; o--) begin
      for (int i = 0; i < NDRV; i++) begin
        if (wrap_add(ptr_q, o) == 2'(i) &&
            (drv_rd[i] || drv_wr[i])) begin
          found = 1'b1;
          gnt   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_lba = '0;
    gnt_wr  = 1'b0;
    for (int i = 0; i < NDRV; i++) begin
      if (gnt == 2'(i)) begin
        gnt_lba = drv_lba[32*i +: 32];
        gnt_wr  = drv_wr[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    lba_d   = lba_q;
    op_d    = op_q;
    busy_d  = busy_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          sel_d   = gnt;
          lba_d   = gnt_lba;
          op_d    = gnt_wr;
          busy_d  = 1'b1;
          rd_d    = !gnt_wr;
          wr_d    = gnt_wr;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        // An ack on the timeout edge still counts as completion.
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RELEASE;
          for (int i = 0; i < NDRV; i++) begin
            if (sel_q == 2'(i)) err_d[i] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        if (old_ack_q && !sd_ack) state_d = RELEASE;
      end
      RELEASE: begin
        busy_d  = 1'b0;
        ptr_d   = wrap_add(sel_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      lba_q     <= '0;
      op_q      <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= '0;
      cnt_q     <= '0;
      old_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      lba_q     <= lba_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      old_ack_q <= sd_ack;
    end
  end

  always_comb begin
    drv_ack     = '0;
    drv_buff_wr = '0;
    for (int i = 0; i < NDRV; i++) begin
      drv_ack[i]     = sd_ack && busy_q && (sel_q == 2'(i));
      drv_buff_wr[i] = sd_buff_wr && busy_q && (sel_q == 2'(i));
    end
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign sd_sel  = sel_q;
  assign busy    = busy_q;
  assign drv_err = err_q;

  logic unused_op;
  assign unused_op = op_q;

endmodule

// File: tb/tb_c1541_sd_arb.sv
// tb_c1541_sd_arb: vector table plus grant scoreboard and
// hand-written sequences for timeout, reset and routing corners.
module tb_c1541_sd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] drv_lba;
  logic [1:0]  drv_rd, drv_wr;
  logic [1:0]  drv_ack, drv_buff_wr, drv_err;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr;
  logic [1:0]  sd_sel;
  logic        busy;

  c1541_sd_arb #(
    .NDRV    (2),
    .TIMEOUT (24'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .drv_lba     (drv_lba),
    .drv_rd      (drv_rd),
    .drv_wr      (drv_wr),
    .drv_ack     (drv_ack),
    .drv_buff_wr (drv_buff_wr),
    .drv_err     (drv_err),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_sel      (sd_sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] lba;
    logic        wr;
  } exp_t;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] lba0;
    logic [31:0] lba1;
    int          dly;
    int          len;
    logic [1:0]  esel;
    logic [31:0] elba;
    logic        ewr;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [31:0] lba,
                      input logic wr);
    exp_t e;
    e.sel = sel;
    e.lba = lba;
    e.wr  = wr;
    q.push_back(e);
  endtask

  task automatic wait_grant(input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (sd_rd || sd_wr) seen = 1'b1;
    end
    chk({name, " grant seen"}, 32'(seen), 1);
    if (seen) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s: got grant expected none", name);
      end else begin
        e = q.pop_front();
        chk({name, " sel"}, 32'(sd_sel), 32'(e.sel));
        chk({name, " lba"}, sd_lba, e.lba);
        chk({name, " wr"}, 32'(sd_wr), 32'(e.wr));
        chk({name, " rd"}, 32'(sd_rd), 32'(!e.wr));
        chk({name, " busy"}, 32'(busy), 1);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    @(negedge clk);
    chk({name, " busy hold"}, 32'(busy), 1);
    chk({name, " ack off"}, 32'(drv_ack), 0);
    @(negedge clk);
    chk({name, " busy release"}, 32'(busy), 1);
    @(negedge clk);
    chk({name, " busy low"}, 32'(busy), 0);
  endtask

  task automatic serve(input logic [1:0] drv, input logic [31:0] lba,
                       input int dly, input int len, input bit drop,
                       input bit chg);
    logic [1:0] oh;
    oh = 2'b01 << drv;
    repeat (dly) @(posedge clk);
    @(posedge clk);
    #1 sd_ack = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("drv_ack route", 32'(drv_ack), 32'(oh));
      chk("sd_lba frozen", sd_lba, lba);
      chk("sd_sel frozen", 32'(sd_sel), 32'(drv));
      if (k > 0) chk("req cleared", 32'({sd_rd, sd_wr}), 0);
      @(posedge clk);
      #1;
      if (k == 0 && drop) begin
        drv_rd[drv] = 1'b0;
        drv_wr[drv] = 1'b0;
      end
      if (k == 0 && chg) drv_lba[32*drv +: 32] = ~lba;
    end
    sd_ack = 1'b0;
    wait_idle("serve");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, errs, b0, b1;
    tbl[0] = '{2'b01, 2'b00, 32'h1111_0001, 32'h2222_0001, 1, 4,
               2'd0, 32'h1111_0001, 1'b0};
    tbl[1] = '{2'b00, 2'b10, 32'h1111_0002, 32'h2222_0002, 0, 2,
               2'd1, 32'h2222_0002, 1'b1};
    tbl[2] = '{2'b10, 2'b10, 32'h1111_0003, 32'h2222_0003, 3, 1,
               2'd1, 32'h2222_0003, 1'b1};
    tbl[3] = '{2'b01, 2'b01, 32'h1111_0004, 32'h2222_0004, 0, 1,
               2'd0, 32'h1111_0004, 1'b1};
    tbl[4] = '{2'b10, 2'b00, 32'h1111_0005, 32'h2222_0005, 5, 3,
               2'd1, 32'h2222_0005, 1'b0};
    tbl[5] = '{2'b00, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 2, 2,
               2'd0, 32'hFFFF_FFFF, 1'b1};

    reset      = 1'b1;
    drv_lba    = '0;
    drv_rd     = '0;
    drv_wr     = '0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sd_rd", 32'(sd_rd), 0);
    chk("rst sd_wr", 32'(sd_wr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst sd_sel", 32'(sd_sel), 0);
    chk("rst sd_lba", sd_lba, 0);
    chk("rst drv_err", 32'(drv_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    sd_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle ack drv_ack", 32'(drv_ack), 0);
      chk("idle ack busy", 32'(busy), 0);
      chk("idle ack sd_rd", 32'(sd_rd), 0);
    end
    @(posedge clk);
    #1 sd_ack = 1'b0;

    @(posedge clk);
    #1;
    drv_rd            = 2'b01;
    drv_lba[31:0]     = 32'd357;
    @(negedge clk);
    chk("single rd early", 32'(sd_rd), 0);
    @(negedge clk);
    chk("single rd", 32'(sd_rd), 1);
    chk("single lba", sd_lba, 32'd357);
    chk("single sel", 32'(sd_sel), 0);
    chk("single busy", 32'(busy), 1);
    serve(2'd0, 32'd357, 2, 10, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      drv_lba = {tbl[i].lba1, tbl[i].lba0};
      drv_rd  = tbl[i].rd;
      drv_wr  = tbl[i].wr;
      push(tbl[i].esel, tbl[i].elba, tbl[i].ewr);
      wait_grant("vec");
      serve(tbl[i].esel, tbl[i].elba, tbl[i].dly, tbl[i].len,
            1'b1, 1'b0);
    end

    @(posedge clk);
    #1;
    reset   = 1'b1;
    drv_lba = {32'h0000_000B, 32'h0000_000A};
    drv_rd  = 2'b01;
    drv_wr  = 2'b10;
    @(posedge clk);
    #1 reset = 1'b0;
    push(2'd0, 32'h0000_000A, 1'b0);
    push(2'd1, 32'h0000_000B, 1'b1);
    push(2'd0, 32'h0000_000A, 1'b0);
    push(2'd1, 32'h0000_000B, 1'b1);
    for (int g = 0; g < 4; g++) begin
      wait_grant("rr");
      serve(g[0] ? 2'd1 : 2'd0, g[0] ? 32'h0000_000B : 32'h0000_000A,
            1, 3, 1'b0, 1'b0);
    end
    drv_rd = '0;
    drv_wr = '0;

    @(posedge clk);
    #1;
    drv_lba = {32'h0000_0B0F, 32'h0000_0000};
    drv_rd  = 2'b10;
    push(2'd1, 32'h0000_0B0F, 1'b0);
    wait_grant("buf");
    @(posedge clk);
    #1;
    sd_ack = 1'b1;
    drv_rd = '0;
    b0 = 0;
    b1 = 0;
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk);
      #1 sd_buff_wr = ~sd_buff_wr;
      @(negedge clk);
      if (drv_buff_wr[0]) b0++;
      if (drv_buff_wr[1]) b1++;
    end
    chk("buf drv1 pulses", 32'(b1), 512);
    chk("buf drv0 pulses", 32'(b0), 0);
    @(posedge clk);
    #1 sd_ack = 1'b0;
    wait_idle("buf");

    @(posedge clk);
    #1;
    drv_lba = {32'hDEAD_0001, 32'h0000_0777};
    drv_wr  = 2'b10;
    push(2'd1, 32'hDEAD_0001, 1'b1);
    wait_grant("tmo");
    drv_rd[0] = 1'b1;
    n    = 0;
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (drv_err != 2'b00) errs++;
      if (!sd_wr) break;
    end
    chk("tmo cycles", 32'(n), 100);
    chk("tmo err", 32'(drv_err), 32'(2'b10));
    chk("tmo err early", 32'(errs), 1);
    drv_wr = '0;
    @(negedge clk);
    chk("tmo err pulse", 32'(drv_err), 0);
    push(2'd0, 32'h0000_0777, 1'b0);
    wait_grant("tmo next");
    serve(2'd0, 32'h0000_0777, 1, 2, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    drv_lba = {32'h0000_0000, 32'h0000_0ACE};
    drv_wr  = 2'b01;
    push(2'd0, 32'h0000_0ACE, 1'b1);
    wait_grant("race");
    repeat (99) @(posedge clk);
    #1 sd_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("race sd_wr", 32'(sd_wr), 0);
    chk("race err", 32'(drv_err), 0);
    chk("race busy", 32'(busy), 1);
    drv_wr = '0;
    @(negedge clk);
    chk("race err late", 32'(drv_err), 0);
    chk("race ack", 32'(drv_ack), 32'(2'b01));
    @(posedge clk);
    #1 sd_ack = 1'b0;
    wait_idle("race");

    @(posedge clk);
    #1;
    drv_lba = {32'h0000_0000, 32'h0000_0D11};
    drv_rd  = 2'b01;
    push(2'd0, 32'h0000_0D11, 1'b0);
    wait_grant("chg");
    serve(2'd0, 32'h0000_0D11, 1, 5, 1'b1, 1'b1);

    @(posedge clk);
    #1;
    drv_lba = {32'h0000_0B22, 32'h0000_0A22};
    drv_rd  = 2'b01;
    push(2'd0, 32'h0000_0A22, 1'b0);
    wait_grant("rst");
    @(posedge clk);
    #1 sd_ack = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst xfer sd_rd", 32'(sd_rd), 0);
    chk("rst xfer sd_wr", 32'(sd_wr), 0);
    chk("rst xfer busy", 32'(busy), 0);
    chk("rst xfer ack", 32'(drv_ack), 0);
    chk("rst xfer err", 32'(drv_err), 0);
    sd_ack = 1'b0;
    drv_rd = 2'b11;
    push(2'd0, 32'h0000_0A22, 1'b0);
    wait_grant("rst first");
    serve(2'd0, 32'h0000_0A22, 0, 2, 1'b1, 1'b0);
    push(2'd1, 32'h0000_0B22, 1'b0);
    wait_grant("rst second");
    serve(2'd1, 32'h0000_0B22, 0, 2, 1'b1, 1'b0);

    chk("sb empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
